hazard_ctrl: RTL
================

# hazard_ctrl

- Central pipeline sequencer for the five-stage pipelined core.
- Drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Resolves data-memory wait, taken-branch squash, load-use and multiply/divide (HI/LO) hazards in a fixed priority.
- Tracks the multi-cycle mul/div unit occupancy and maintains a saturating stall-cycle performance counter.

## Interface

- MD_LAT, 32, cycles the mul/div unit is busy after issue (≥1)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ID_RS  in  5  rs index of instruction in ID
- ID_RT  in  5  rt index of instruction in ID
- ID_USES_RT  in  1  ID instruction reads rt as a source
- ID_MD_READ  in  1  ID instruction is mfhi/mflo or a new mul/div
- EX_MEMREAD  in  1  instruction in EX is a load
- EX_RT  in  5  load destination register in EX
- EX_BR_TAKEN  in  1  branch/jump in EX resolved taken
- EX_MD_START  in  1  mul/div instruction in EX issues to unit
- MEM_WAIT  in  1  data memory not ready; MEM cannot complete
- PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN  out  1 each  stage register enables
- IFID_FLUSH, IDEX_FLUSH  out  1 each  register loads NOP (all zero) at next edge when its EN=1
- MD_BUSY  out  1  mul/div unit occupied
- STALL_CNT  out  16  cycles with PC_EN=0 since reset, saturating

## Operation

- Enables/flushes are combinational from inputs and registered state; MD_BUSY and STALL_CNT are registered.
- While RST=1: PC_EN=0, IFID_EN=IDEX_EN=EXMEM_EN=MEMWB_EN=1, IFID_FLUSH=IDEX_FLUSH=1 (pipeline fills with NOPs). At the edge, MD state is set to IDLE and STALL_CNT to 0.
- When RST=0, decision priority per cycle (first match wins):
  1. **MEM_WAIT=1**: all five EN=0, flushes=0 (full freeze).
  2. **EX_BR_TAKEN=1**: all EN=1, IFID_FLUSH=1, IDEX_FLUSH=1. Squashes both younger instructions and overrides the hazards below.
  3. **Load-use**: EX_MEMREAD and EX_RT≠0 and (EX_RT==ID_RS, or ID_USES_RT and EX_RT==ID_RT). Outputs PC_EN=0, IFID_EN=0, IDEX_FLUSH=1 (bubble); IDEX/EXMEM/MEMWB EN=1.
  4. **MD hazard**: MD_BUSY and ID_MD_READ. Same outputs as load-use.
  5. **Otherwise**: all EN=1, flushes=0.
- Register 0 never causes a load-use stall.
- MD FSM, states IDLE and BUSY, with counter width clog2(MD_LAT+1):
  - IDLE→BUSY on an edge where EX_MD_START=1 and MEM_WAIT=0. Counter loads MD_LAT.
  - BUSY: counter decrements every edge regardless of MEM_WAIT. BUSY→IDLE on the edge where the counter reaches 0.
  - EX_MD_START=1 (MEM_WAIT=0) while BUSY: counter reloads MD_LAT (restart).
  - EX_MD_START while MEM_WAIT=1 is ignored; it is sampled when EX advances.
- MD_BUSY=1 exactly in state BUSY.
- STALL_CNT increments on each edge with RST=0 and PC_EN=0, holding at 0xFFFF.

## Timing

- Start sampled at edge k gives MD_BUSY=1 for cycles k+1 … k+MD_LAT and 0 from cycle k+MD_LAT+1.
- An ID_MD_READ stall is released in the first cycle MD_BUSY=0.
- Load-use costs exactly one bubble: the stall cycle is followed by the load in MEM, and the ID instruction advances with forwarding.
- Branch penalty: 2 squashed instructions, no stall cycle.
- MEM_WAIT combined with any hazard: freeze only. The hazard is re-evaluated when MEM_WAIT drops, because inputs are unchanged.
- RST asserted mid-stall or mid-BUSY: RST outputs apply in the same cycle, and the FSM is IDLE after the edge.

## Test plan

- **Reset**: RST=1 for 2 cycles → PC_EN=0, IFID_FLUSH=IDEX_FLUSH=1, MD_BUSY=0, STALL_CNT=0 after the edge.
- **Load-use**: EX_MEMREAD=1, EX_RT=8, ID_RS=8 → one cycle with PC_EN=0, IFID_EN=0, IDEX_FLUSH=1; STALL_CNT=1.
  - Repeat with EX_RT=0 → no stall.
  - Repeat with ID_RT=8 and ID_USES_RT=0 → no stall.
- **Branch vs load-use**: EX_BR_TAKEN=1 with the load-use condition also true → all EN=1, both flushes=1, STALL_CNT unchanged.
- **MD stall**: MD_LAT=4, EX_MD_START pulse at edge 0, ID_MD_READ=1 held → MD_BUSY and stall in cycles 1–4, released in cycle 5, STALL_CNT=4.
- **MEM_WAIT freeze**: MEM_WAIT=1 for 3 cycles during MD BUSY and with EX_BR_TAKEN=1 → all EN=0 and flushes=0. MD counter still decrements. Flush appears in the cycle after MEM_WAIT falls.
- **Saturation/reset mid-op**:
  - Hold the load-use condition for 70000 cycles → STALL_CNT=0xFFFF, stays 0xFFFF.
  - Assert RST during MD BUSY → MD_BUSY=0 and STALL_CNT=0 after the edge.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: the pipeline status signals it reads and the stage
// enables/flushes it drives.
//   master : pipeline side (drives status, reads enables/flushes/MD_BUSY/STALL_CNT)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if;
  logic [4:0]  ID_RS;
  logic [4:0]  ID_RT;
  logic        ID_USES_RT;
  logic        ID_MD_READ;
  logic        EX_MEMREAD;
  logic [4:0]  EX_RT;
  logic        EX_BR_TAKEN;
  logic        EX_MD_START;
  logic        MEM_WAIT;
  logic        PC_EN;
  logic        IFID_EN;
  logic        IDEX_EN;
  logic        EXMEM_EN;
  logic        MEMWB_EN;
  logic        IFID_FLUSH;
  logic        IDEX_FLUSH;
  logic        MD_BUSY;
  logic [15:0] STALL_CNT;

  modport master (
    output ID_RS, ID_RT, ID_USES_RT, ID_MD_READ, EX_MEMREAD, EX_RT,
           EX_BR_TAKEN, EX_MD_START, MEM_WAIT,
    input  PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN, IFID_FLUSH,
           IDEX_FLUSH, MD_BUSY, STALL_CNT
  );

  modport slave (
    input  ID_RS, ID_RT, ID_USES_RT, ID_MD_READ, EX_MEMREAD, EX_RT,
           EX_BR_TAKEN, EX_MD_START, MEM_WAIT,
    output PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN, IFID_FLUSH,
           IDEX_FLUSH, MD_BUSY, STALL_CNT
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the five-stage core. Produces stage-register
// enables/flushes from a fixed hazard priority (mem wait > taken branch >
// load-use > mul/div busy), tracks mul/div unit occupancy and counts stall
// cycles (saturating).
//   CLK, RST : clock, synchronous active-high reset
//   hif      : hazard_ctrl_if.slave (status in; enables, flushes, MD_BUSY,
//              STALL_CNT out)
module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_ctrl_if.slave hif
);
  localparam int CW = $clog2(MD_LAT + 1);

  typedef enum logic {MD_IDLE, MD_BUSY_S} md_state_e;

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic load_use, md_haz, md_start;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = hif.EX_MEMREAD && (hif.EX_RT != 5'd0) &&
                    ((hif.EX_RT == hif.ID_RS) ||
                     (hif.ID_USES_RT && (hif.EX_RT == hif.ID_RT)));
  assign md_haz   = (state_q == MD_BUSY_S) && hif.ID_MD_READ;
  // A start is only real once EX actually advances.
  assign md_start = hif.EX_MD_START && !hif.MEM_WAIT;

  always_comb begin
    pc_en = 1'b1; ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
    memwb_en = 1'b1; ifid_fl = 1'b0; idex_fl = 1'b0;
    if (RST) begin
      pc_en = 1'b0; ifid_fl = 1'b1; idex_fl = 1'b1;
    end else if (hif.MEM_WAIT) begin
      pc_en = 1'b0; ifid_en = 1'b0; idex_en = 1'b0;
      exmem_en = 1'b0; memwb_en = 1'b0;
    end else if (hif.EX_BR_TAKEN) begin
      ifid_fl = 1'b1; idex_fl = 1'b1;
    end else if (load_use || md_haz) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      pc_en = 1'b0; ifid_en = 1'b0; idex_fl = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY_S;
          cnt_d   = CW'(MD_LAT);
        end
      end
      MD_BUSY_S: begin
        if (md_start) begin
          cnt_d = CW'(MD_LAT);
        end else begin
          // Decrements even under MEM_WAIT: the unit runs independently.
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hif.PC_EN      = pc_en;
  assign hif.IFID_EN    = ifid_en;
  assign hif.IDEX_EN    = idex_en;
  assign hif.EXMEM_EN   = exmem_en;
  assign hif.MEMWB_EN   = memwb_en;
  assign hif.IFID_FLUSH = ifid_fl;
  assign hif.IDEX_FLUSH = idex_fl;
  assign hif.MD_BUSY    = (state_q == MD_BUSY_S);
  assign hif.STALL_CNT  = stall_cnt_q;
endmodule
